// File: rtl/uart_pkg.sv
// Shared UART constants: default oversample ratio, reset divisor and a helper that
// derives an integer+fractional divisor from clock and baud rate at elaboration.
package uart_pkg;

  localparam int unsigned DEF_OVERSAMPLE   = 16;
  localparam int unsigned DEF_INT_W        = 16;
  localparam int unsigned DEF_FRAC_W       = 4;
  localparam int unsigned DEF_RST_DIV_INT  = 163;
  localparam int unsigned DEF_RST_DIV_FRAC = 0;
  localparam longint unsigned DEF_CLK_HZ   = 64'd50_000_000;

  typedef struct packed {
    logic [DEF_INT_W-1:0]  div_int;
    logic [DEF_FRAC_W-1:0] div_frac;
  } baud_div_t;

  // Rounded clk_hz / (baud * oversample) in fixed point with DEF_FRAC_W fraction bits.
  function automatic baud_div_t calc_baud_div(input longint unsigned clk_hz,
                                              input longint unsigned baud);
    longint unsigned denom;
    longint unsigned fixed_div;
    denom     = baud * 64'(DEF_OVERSAMPLE);
    fixed_div = ((clk_hz << DEF_FRAC_W) + (denom >> 1)) / denom;
    return fixed_div[DEF_INT_W+DEF_FRAC_W-1:0];
  endfunction

  localparam baud_div_t DIV_2400  = calc_baud_div(DEF_CLK_HZ, 64'd2400);
  localparam baud_div_t DIV_4800  = calc_baud_div(DEF_CLK_HZ, 64'd4800);
  localparam baud_div_t DIV_9600  = calc_baud_div(DEF_CLK_HZ, 64'd9600);
  localparam baud_div_t DIV_19200 = calc_baud_div(DEF_CLK_HZ, 64'd19200);

endpackage

// File: rtl/uart_frac_accum.sv
// Fractional phase accumulator: adds the fractional divisor once per oversample interval
// and holds the carry that stretches the following interval by one cycle.
module uart_frac_accum
  import uart_pkg::*;
#(
  parameter int unsigned FRAC_W = DEF_FRAC_W
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_clear,
  input  logic              i_step,
  input  logic [FRAC_W-1:0] i_frac,
  output logic              o_carry
);

  logic [FRAC_W-1:0] r_acc;
  logic              r_carry;
  logic [FRAC_W:0]   w_sum;

  assign w_sum = {1'b0, r_acc} + {1'b0, i_frac};

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_acc   <= '0;
      r_carry <= 1'b0;
    end else if (i_clear) begin
      r_acc   <= '0;
      r_carry <= 1'b0;
    end else if (i_step) begin
      r_acc   <= w_sum[FRAC_W-1:0];
      r_carry <= w_sum[FRAC_W];
    end
  end

  assign o_carry = r_carry;

endmodule

// File: rtl/uart_frac_baud_gen.sv
// UART baud generator with integer+fractional divisor, producing oversample, mid-bit and
// bit-boundary ticks; divisor updates are staged in a shadow and applied at bit boundaries.
module uart_frac_baud_gen
  import uart_pkg::*;
#(
  parameter int unsigned INT_W        = DEF_INT_W,
  parameter int unsigned FRAC_W       = DEF_FRAC_W,
  parameter int unsigned OVERSAMPLE   = DEF_OVERSAMPLE,
  parameter int unsigned RST_DIV_INT  = DEF_RST_DIV_INT,
  parameter int unsigned RST_DIV_FRAC = DEF_RST_DIV_FRAC
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic                          i_en,
  input  logic                          i_resync,
  input  logic                          i_cfg_load,
  input  logic [INT_W-1:0]              i_cfg_div_int,
  input  logic [FRAC_W-1:0]             i_cfg_div_frac,
  output logic                          o_cfg_pending,
  output logic                          o_os_tick,
  output logic                          o_mid_tick,
  output logic                          o_bit_tick,
  output logic [$clog2(OVERSAMPLE)-1:0] o_os_index
);

  localparam int unsigned IDX_W = $clog2(OVERSAMPLE);
  localparam logic [IDX_W-1:0] IDX_MID  = IDX_W'(OVERSAMPLE / 2 - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(OVERSAMPLE - 1);
  localparam logic [INT_W-1:0] DIV_MIN  = INT_W'(2);

  logic [INT_W-1:0]  r_div_int;
  logic [FRAC_W-1:0] r_div_frac;
  logic [INT_W-1:0]  r_shd_int;
  logic [FRAC_W-1:0] r_shd_frac;
  logic              r_pending;
  logic [INT_W-1:0]  r_cnt;
  logic [IDX_W-1:0]  r_idx;

  logic [INT_W-1:0]  w_div_eff;
  logic [INT_W:0]    w_period_m1;
  logic              w_clear;
  logic              w_carry;
  logic              w_last;
  logic              w_os_tick;
  logic              w_bit_tick;
  logic              w_apply;

  assign w_clear     = ~i_en | i_resync;
  assign w_div_eff   = (r_div_int < DIV_MIN) ? DIV_MIN : r_div_int;
  // Interval length is D plus the carry left by the previous interval's accumulation.
  assign w_period_m1 = {1'b0, w_div_eff} + {{INT_W{1'b0}}, w_carry}
                     - {{INT_W{1'b0}}, 1'b1};
  assign w_last      = ({1'b0, r_cnt} == w_period_m1);
  assign w_os_tick   = w_last & ~w_clear;
  assign w_bit_tick  = w_os_tick & (r_idx == IDX_LAST);
  assign w_apply     = r_pending & (w_bit_tick | ~i_en);

  uart_frac_accum #(
    .FRAC_W(FRAC_W)
  ) u_frac_accum (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_clear(w_clear),
    .i_step (w_os_tick),
    .i_frac (r_div_frac),
    .o_carry(w_carry)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt <= '0;
      r_idx <= '0;
    end else if (w_clear) begin
      r_cnt <= '0;
      r_idx <= '0;
    end else if (w_last) begin
      r_cnt <= '0;
      r_idx <= (r_idx == IDX_LAST) ? '0 : r_idx + IDX_W'(1);
    end else begin
      r_cnt <= r_cnt + INT_W'(1);
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_div_int  <= INT_W'(RST_DIV_INT);
      r_div_frac <= FRAC_W'(RST_DIV_FRAC);
      r_shd_int  <= '0;
      r_shd_frac <= '0;
      r_pending  <= 1'b0;
    end else if (i_cfg_load && !i_en) begin
      // Counters are idle, so a new divisor can take effect straight away.
      r_div_int  <= i_cfg_div_int;
      r_div_frac <= i_cfg_div_frac;
      r_pending  <= 1'b0;
    end else begin
      if (w_apply) begin
        r_div_int  <= r_shd_int;
        r_div_frac <= r_shd_frac;
      end
      if (i_cfg_load) begin
        r_shd_int  <= i_cfg_div_int;
        r_shd_frac <= i_cfg_div_frac;
      end
      r_pending <= i_cfg_load | (r_pending & ~w_apply);
    end
  end

  assign o_cfg_pending = r_pending;
  assign o_os_tick     = w_os_tick;
  assign o_mid_tick    = w_os_tick & (r_idx == IDX_MID);
  assign o_bit_tick    = w_bit_tick;
  assign o_os_index    = r_idx;

endmodule

// File: doc/uart_frac_baud_gen.md
Name: uart_frac_baud_gen

Overview:
Parametrised successor of the UART baud generator. Produces single-cycle oversample ticks (os_tick), mid-bit sample ticks (mid_tick) and bit-boundary ticks (bit_tick) from a runtime-programmable integer+fractional divisor. A fractional accumulator removes rate error at arbitrary clock frequencies. A resync input lets the receiver realign phase on a start-bit edge. Shared by the UART transmitter and receiver; one instance per direction.

Parameters:
INT_W, 16, width of integer divisor (clk cycles per oversample tick)
FRAC_W, 4, width of fractional divisor (units of 1/2^FRAC_W cycle)
OVERSAMPLE, 16, oversample ticks per bit; even, >= 4
RST_DIV_INT, 163, integer divisor loaded at reset
RST_DIV_FRAC, 0, fractional divisor loaded at reset

Ports:
clk  in  1  main clock
rst  in  1  asynchronous, active-high reset
en  in  1  run enable; low = counters held at start-of-bit, no ticks
resync  in  1  one-cycle pulse; restart bit phase
cfg_load  in  1  one-cycle pulse; capture cfg_div_int/cfg_div_frac into shadow
cfg_div_int  in  INT_W  new integer divisor
cfg_div_frac  in  FRAC_W  new fractional divisor
cfg_pending  out  1  shadow divisor captured, not yet applied
os_tick  out  1  oversample tick pulse
mid_tick  out  1  pulse at middle of bit (os index OVERSAMPLE/2-1)
bit_tick  out  1  pulse at end of bit (os index OVERSAMPLE-1)
os_index  out  $clog2(OVERSAMPLE)  current oversample index within bit

Behaviour:
- Reset: all outputs 0; active divisor = RST_DIV_INT/RST_DIV_FRAC; cycle counter, os_index, frac accumulator = 0.
- Effective integer divisor D = max(div_int, 2); values 0/1 clamped to 2.
- Period P of each oversample interval = D + c; c = carry out of (frac_acc + div_frac) at the end of the previous interval; first interval after reset/enable/resync has c = 0.
- Cycle counter counts 0..P-1 while en=1; os_tick is high in the cycle the counter equals P-1; counter then wraps to 0 and frac_acc <= (frac_acc + div_frac) mod 2^FRAC_W.
- With en high from reset release, the first os_tick is high in cycle index P-1 (cycles counted from 0 at the first enabled edge); ticks are exactly 1 clk wide and never back-to-back.
- os_index increments on each os_tick, wrapping OVERSAMPLE-1 -> 0. mid_tick = os_tick && os_index==OVERSAMPLE/2-1; bit_tick = os_tick && os_index==OVERSAMPLE-1 (combinational from registered state, same cycle as os_tick).
- en low: cycle counter, os_index and frac_acc forced to 0; no ticks; configuration is still accepted.
- resync: same clearing as en low, for one cycle; overrides an os_tick falling in that same cycle (tick suppressed). Next os_tick occurs P cycles after the resync cycle.
- cfg_load: captures into the shadow register and sets cfg_pending. The shadow is transferred to the active divisor at the next bit boundary (the cycle bit_tick is high), or immediately if en=0. cfg_pending clears in that same cycle. A second cfg_load while pending overwrites the shadow (last write wins). A cfg_load coinciding with the apply cycle is kept pending for the next boundary.
- Active divisor never changes mid-bit while en=1.
- rst asserted mid-operation: immediate return to reset state; a pending config is discarded.

Decomposition:
- Package uart_pkg: OVERSAMPLE default; reset divisor constants; function computing {div_int, div_frac} from CLK_HZ and baud at elaboration; preset constants for 2400/4800/9600/19200.
- One sub-module: uart_frac_accum (fractional accumulator + carry, clear input). Counter, tick decode and shadow logic stay in the top.

Test Plan:
- Reset defaults: rst high then low, en=1, div 163/0 -> os_tick every 163 cycles, first at cycle 162; bit_tick every 2608 cycles; mid_tick 1304 cycles before each bit_tick.
- Fractional: load 325/8 while en=0, en=1 -> os periods alternate 325,326,...; bit_tick spacing exactly 5208 cycles over 10 bits.
- Clamp: div_int=0 and div_int=1 -> os_tick every 2 cycles, never continuous high.
- Deferred config: at os_index 5, load 81/0 -> cfg_pending=1 until the bit_tick, old period retained until then, 81-cycle periods afterwards.
- Resync: pulse resync in the same cycle as an expected os_tick -> tick suppressed, os_index=0, next os_tick exactly P cycles later; mid_tick at os_index 7.
- Async reset mid-bit with cfg_pending=1 -> all outputs 0 without a clock edge; after release, divisor = 163/0 and cfg_pending=0.
